dsram_arbiter: RTL and testbench
================================

// Module: dsram_arbiter
// PURPOSE
//  Shares the single data SRAM port between the pipeline load/store path (EX issues, MEM consumes
//  data_sram_rdata) and an auxiliary master (debug/DMA) on a valid/ready handshake. Pipeline has
//  priority; an aged-wait counter guarantees aux progress by forcing a pipeline stall request.
//  Sits between EX/MEM and the SRAM; cpu_stallreq feeds the stall controller.
// PARAMETERS
//  MAX_WAIT  8  cycles aux may wait while pipeline wins before aux is forced; 0 = aux always wins
//  CW        4  width of wait counter; must hold MAX_WAIT
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset: synchronous, active-high
//  cpu_en        in   1   pipeline access request this cycle (from EX)
//  cpu_wen       in   4   byte write enables; 0 = read
//  cpu_addr      in   32  byte address
//  cpu_wdata     in   32  store data
//  cpu_stallreq  out  1   pipeline request denied this cycle; EX must re-present it
//  cpu_rdata     out  32  load data for MEM stage
//  aux_valid     in   1   aux request valid
//  aux_ready     out  1   aux request accepted (granted) this cycle
//  aux_wen       in   4   aux byte write enables; 0 = read
//  aux_addr      in   32  aux byte address
//  aux_wdata     in   32  aux store data
//  aux_rsp_valid out  1   aux read data valid
//  aux_rdata     out  32  aux read data
//  sram_en/sram_wen/sram_addr/sram_wdata out 1/4/32/32  SRAM request; sram_rdata in 32, 1-cycle latency
// BEHAVIOUR
//  - Per-cycle grant (combinational from inputs + state):
//    force = aux_valid && wait_cnt==MAX_WAIT.
//    cpu_en && !force -> grant CPU; aux_ready=0.
//    else aux_valid -> grant AUX; aux_ready=1; cpu_stallreq=cpu_en.
//    else no grant; sram_en=0.
//  - SRAM outputs mux from granted requester; sram_wen/addr/wdata=0 when no grant.
//  - wait_cnt: cleared on AUX grant or !aux_valid; +1 when aux_valid and CPU granted; saturates at MAX_WAIT.
//  - owner_q <= {NONE,CPU_RD,AUX_RD} for a granted read, NONE for writes/idle.
//  - cpu_rdata = sram_rdata when owner_q==CPU_RD, else cpu_rdata_q (last CPU read data, held
//    so a stalled MEM stage sees stable data); cpu_rdata_q <= sram_rdata when owner_q==CPU_RD.
//  - aux_rsp_valid = (owner_q==AUX_RD), aux_rdata = sram_rdata that cycle; writes get no response.
//  - aux must hold payload stable while aux_valid && !aux_ready.
//  - Back-to-back grants allowed every cycle; no bubbles inserted.
//  - Reset: wait_cnt=0, owner_q=NONE, cpu_rdata_q=0; outputs after reset with idle inputs:
//    all sram_* 0, aux_ready 0, aux_rsp_valid 0, cpu_stallreq 0, cpu_rdata 0.
//    Reset during an outstanding read drops the response (aux_rsp_valid stays 0).
//  - MAX_WAIT=0: force whenever aux_valid; pipeline stalls for every aux cycle.
// STRUCTURE
//  - defines.vh: owner encodings OWN_NONE/OWN_CPU_RD/OWN_AUX_RD (2 bits).
//  - One sub-module: sat_counter (CW-bit, clear/inc/saturate at MAX_WAIT) for wait_cnt.
// TESTING
//  1 cpu read 0x100 alone, sram_rdata=0xDEADBEEF next cycle -> cpu_rdata=0xDEADBEEF, stallreq never 1.
//  2 aux read 0x40 with cpu idle -> aux_ready same cycle, aux_rsp_valid+data exactly 1 cycle later.
//  3 cpu_en and aux_valid held continuously, MAX_WAIT=8 -> 8 CPU grants, then 1 AUX grant with
//    cpu_stallreq=1, counter restarts; pattern repeats 8:1.
//  4 aux read granted, next cycle cpu stalled -> cpu_rdata keeps previous CPU load value, not aux data.
//  5 aux write wen=4'b0011 -> sram_wen=0011, no aux_rsp_valid; cpu store same cycle stalls only if forced.
//  6 rst asserted in cycle after aux read grant -> aux_rsp_valid=0, wait_cnt=0, all sram_* 0.

Source files
------------

// File: rtl/dsram_arbiter_pkg.sv
// Shared types and helpers for the data SRAM arbiter.
//   owner_e  : who owns the SRAM read data returning in the current cycle
//   is_read  : a zero byte-enable mask means the request is a load
package dsram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_AUX_RD = 2'd2
    } owner_e;

    localparam int DEFAULT_MAX_WAIT = 8;
    localparam int DEFAULT_CW       = 4;

    function automatic logic is_read(input logic [3:0] wen);
        return (wen == 4'b0000);
    endfunction

endpackage

// File: rtl/dsram_arbiter_sat_counter.sv
// Saturating up-counter used to age a waiting auxiliary request.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (takes precedence over inc)
//   inc      : increment by one, holding at MAX
//   cnt      : current count
//   at_max   : cnt has reached MAX
module dsram_arbiter_sat_counter
    import dsram_arbiter_pkg::*;
#(
    parameter int CW  = DEFAULT_CW,
    parameter int MAX = DEFAULT_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    localparam logic [CW-1:0] MAX_V = CW'(MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign at_max = (cnt == MAX_V);

endmodule

// File: rtl/dsram_arbiter.sv
// Shares the single data SRAM port between the pipeline load/store path and an
// auxiliary (debug/DMA) master. The pipeline has priority; an aged-wait counter
// forces an aux grant (and a pipeline stall request) once aux has lost MAX_WAIT
// times in a row.
//   clk, rst                          : clock, synchronous active-high reset
//   cpu_en/cpu_wen/cpu_addr/cpu_wdata : pipeline request from EX
//   cpu_stallreq                      : pipeline request denied, EX re-presents it
//   cpu_rdata                         : load data for MEM, held between CPU loads
//   aux_valid/aux_wen/aux_addr/aux_wdata, aux_ready : aux valid/ready request
//   aux_rsp_valid/aux_rdata           : aux read response, one cycle after grant
//   sram_en/sram_wen/sram_addr/sram_wdata, sram_rdata : SRAM port (1-cycle read)
module dsram_arbiter
    import dsram_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CW       = DEFAULT_CW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stallreq,
    output logic [31:0] cpu_rdata,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [3:0]  aux_wen,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_rsp_valid,
    output logic [31:0] aux_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    logic [CW-1:0] wait_cnt;
    logic          wait_full;
    logic          force_aux;
    logic          grant_cpu;
    logic          grant_aux;
    owner_e        owner_q;
    owner_e        owner_d;
    logic [31:0]   cpu_rdata_q;

    // Aux ages only while it is actually waiting behind a CPU grant; any aux
    // grant or a dropped aux request restarts the count.
    dsram_arbiter_sat_counter #(
        .CW  (CW),
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (grant_aux || !aux_valid),
        .inc    (aux_valid && grant_cpu),
        .cnt    (wait_cnt),
        .at_max (wait_full)
    );

    // Grant is decided fresh every cycle, so back-to-back grants need no
    // bubble. With MAX_WAIT=0 the counter sits at its limit and aux always wins.
    always_comb begin
        force_aux    = aux_valid && wait_full;
        grant_cpu    = cpu_en && !force_aux;
        grant_aux    = !grant_cpu && aux_valid;
        aux_ready    = grant_aux;
        cpu_stallreq = cpu_en && grant_aux;
        sram_en      = 1'b0;
        sram_wen     = 4'b0000;
        sram_addr    = 32'd0;
        sram_wdata   = 32'd0;
        owner_d      = OWN_NONE;
        if (grant_cpu) begin
            sram_en    = 1'b1;
            sram_wen   = cpu_wen;
            sram_addr  = cpu_addr;
            sram_wdata = cpu_wdata;
            owner_d    = is_read(cpu_wen) ? OWN_CPU_RD : OWN_NONE;
        end else if (grant_aux) begin
            sram_en    = 1'b1;
            sram_wen   = aux_wen;
            sram_addr  = aux_addr;
            sram_wdata = aux_wdata;
            owner_d    = is_read(aux_wen) ? OWN_AUX_RD : OWN_NONE;
        end
    end

    // Reset clears owner_q, which also drops any read response in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            cpu_rdata_q <= 32'd0;
        end else begin
            owner_q <= owner_d;
            if (owner_q == OWN_CPU_RD) begin
                cpu_rdata_q <= sram_rdata;
            end
        end
    end

    // MEM sees live SRAM data only in the cycle its own load returns; otherwise
    // it keeps the last CPU load so a stalled MEM stage never picks up aux data.
    assign cpu_rdata     = (owner_q == OWN_CPU_RD) ? sram_rdata : cpu_rdata_q;
    assign aux_rsp_valid = (owner_q == OWN_AUX_RD);
    assign aux_rdata     = sram_rdata;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Self-checking bench for dsram_arbiter: directed vectors with hand-computed
// expected data pushed into scoreboard queues; a monitor pops and compares
// whenever the DUT returns CPU load data or an aux response.
module tb_dsram_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stallreq;
    logic [31:0] cpu_rdata;
    logic        aux_valid;
    logic        aux_ready;
    logic [3:0]  aux_wen;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_rsp_valid;
    logic [31:0] aux_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cpu_q[$];
    logic [31:0] aux_q[$];
    logic [31:0] mem[logic [31:0]];

    logic        mon_en      = 1'b0;
    logic        rst_seen    = 1'b0;
    logic        prev_cpu_rd = 1'b0;
    logic [31:0] held_cpu    = 32'd0;

    dsram_arbiter #(
        .MAX_WAIT (8),
        .CW       (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_en        (cpu_en),
        .cpu_wen       (cpu_wen),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_stallreq  (cpu_stallreq),
        .cpu_rdata     (cpu_rdata),
        .aux_valid     (aux_valid),
        .aux_ready     (aux_ready),
        .aux_wen       (aux_wen),
        .aux_addr      (aux_addr),
        .aux_wdata     (aux_wdata),
        .aux_rsp_valid (aux_rsp_valid),
        .aux_rdata     (aux_rdata),
        .sram_en       (sram_en),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, byte-enabled writes.
    initial sram_rdata = 32'd0;
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen == 4'b0000) begin
                sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : 32'd0;
            end else begin
                logic [31:0] w;
                w = mem.exists(sram_addr) ? mem[sram_addr] : 32'd0;
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                end
                mem[sram_addr] = w;
            end
        end
    end

    always @(posedge clk) rst_seen <= rst;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic c_en, input logic [3:0] c_wen,
                                 input logic [31:0] c_addr, input logic [31:0] c_wdata,
                                 input logic a_valid, input logic [3:0] a_wen,
                                 input logic [31:0] a_addr, input logic [31:0] a_wdata);
        @(posedge clk);
        #1;
        cpu_en    = c_en;
        cpu_wen   = c_wen;
        cpu_addr  = c_addr;
        cpu_wdata = c_wdata;
        aux_valid = a_valid;
        aux_wen   = a_wen;
        aux_addr  = a_addr;
        aux_wdata = a_wdata;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_sram_en"},    {31'd0, sram_en},      32'd0);
        checkOutput({tag, "_sram_wen"},   {28'd0, sram_wen},     32'd0);
        checkOutput({tag, "_sram_addr"},  sram_addr,             32'd0);
        checkOutput({tag, "_sram_wdata"}, sram_wdata,            32'd0);
        checkOutput({tag, "_aux_ready"},  {31'd0, aux_ready},    32'd0);
        checkOutput({tag, "_stallreq"},   {31'd0, cpu_stallreq}, 32'd0);
    endtask

    // Scoreboard monitor: CPU load data is due the cycle after a granted CPU
    // read and held otherwise; aux responses are popped whenever presented.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                if (prev_cpu_rd && cpu_q.size() > 0) void'(cpu_q.pop_front());
                held_cpu = 32'd0;
                checkOutput("cpu_rdata_after_reset", cpu_rdata, 32'd0);
                checkOutput("aux_rsp_dropped_by_reset", {31'd0, aux_rsp_valid}, 32'd0);
            end else begin
                if (prev_cpu_rd) begin
                    if (cpu_q.size() == 0) begin
                        checkOutput("cpu_load_unexpected", 32'd0, 32'd1);
                    end else begin
                        held_cpu = cpu_q.pop_front();
                        checkOutput("cpu_rdata_load", cpu_rdata, held_cpu);
                    end
                end else begin
                    checkOutput("cpu_rdata_hold", cpu_rdata, held_cpu);
                end
                if (aux_rsp_valid) begin
                    if (aux_q.size() == 0) begin
                        checkOutput("aux_rsp_unexpected", {31'd0, aux_rsp_valid}, 32'd0);
                    end else begin
                        checkOutput("aux_rdata", aux_rdata, aux_q.pop_front());
                    end
                end
            end
            prev_cpu_rd = cpu_en && !cpu_stallreq && (cpu_wen == 4'b0000);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem[32'h0000_0100] = 32'hDEAD_BEEF;
        mem[32'h0000_0040] = 32'hCAFE_F00D;
        mem[32'h0000_0200] = 32'h1234_5678;
        mem[32'h0000_0080] = 32'hA5A5_A5A5;

        rst       = 1'b1;
        cpu_en    = 1'b0;
        cpu_wen   = 4'h0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        aux_valid = 1'b0;
        aux_wen   = 4'h0;
        aux_addr  = 32'd0;
        aux_wdata = 32'd0;

        // Reset state with idle inputs.
        applyIdle();
        applyIdle();
        rst = 1'b0;
        applyIdle();
        @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_aux_rsp_valid", {31'd0, aux_rsp_valid}, 32'd0);
        checkOutput("reset_cpu_rdata", cpu_rdata, 32'd0);
        mon_en = 1'b1;

        // CPU read alone.
        applyStimulus(1'b1, 4'h0, 32'h100, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0);
        cpu_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("t1_sram_en",   {31'd0, sram_en},      32'd1);
        checkOutput("t1_sram_addr", sram_addr,             32'h100);
        checkOutput("t1_stallreq",  {31'd0, cpu_stallreq}, 32'd0);
        applyIdle();
        @(negedge clk);
        checkOutput("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Aux read with CPU idle; response exactly one cycle later.
        applyStimulus(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 4'h0, 32'h40, 32'd0);
        aux_q.push_back(32'hCAFE_F00D);
        @(negedge clk);
        checkOutput("t2_aux_ready", {31'd0, aux_ready}, 32'd1);
        checkOutput("t2_sram_addr", sram_addr,          32'h40);
        applyIdle();
        @(negedge clk);
        checkOutput("t2_rsp_valid",   {31'd0, aux_rsp_valid}, 32'd1);
        checkOutput("t2_cpu_rdata_held", cpu_rdata,           32'hDEAD_BEEF);
        applyIdle();
        @(negedge clk);
        checkOutput("t2_rsp_one_cycle", {31'd0, aux_rsp_valid}, 32'd0);

        // Continuous contention: 8 CPU grants then 1 forced aux grant, repeating.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 4'h0, 32'h200, 32'd0, 1'b1, 4'h0, 32'h80, 32'd0);
            if ((i % 9) == 8) aux_q.push_back(32'hA5A5_A5A5);
            else              cpu_q.push_back(32'h1234_5678);
            @(negedge clk);
            checkOutput($sformatf("t3_aux_ready_%0d", i), {31'd0, aux_ready},
                        ((i % 9) == 8) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t3_stallreq_%0d", i), {31'd0, cpu_stallreq},
                        ((i % 9) == 8) ? 32'd1 : 32'd0);
        end
        applyIdle();
        @(negedge clk);
        checkOutput("t4_cpu_rdata_not_aux", cpu_rdata, 32'h1234_5678);

        // Aux write: no response; then CPU store contends with an aux write.
        applyStimulus(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 4'b0011, 32'h40, 32'h1111_2222);
        @(negedge clk);
        checkOutput("t5_sram_wen",   {28'd0, sram_wen}, 32'h3);
        checkOutput("t5_sram_wdata", sram_wdata,        32'h1111_2222);
        checkOutput("t5_aux_ready",  {31'd0, aux_ready}, 32'd1);
        applyStimulus(1'b1, 4'hF, 32'h300, 32'hFFFF_0000, 1'b1, 4'b1100, 32'h44, 32'h3333_4444);
        @(negedge clk);
        checkOutput("t5_cpu_store_wins", {31'd0, cpu_stallreq}, 32'd0);
        checkOutput("t5_aux_waits",      {31'd0, aux_ready},    32'd0);
        checkOutput("t5_store_wen",      {28'd0, sram_wen},     32'hF);
        applyStimulus(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 4'b1100, 32'h44, 32'h3333_4444);
        @(negedge clk);
        checkOutput("t5_aux_write_granted", {31'd0, aux_ready}, 32'd1);
        checkOutput("t5_aux_write_addr",    sram_addr,          32'h44);
        applyStimulus(1'b1, 4'h0, 32'h300, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0);
        cpu_q.push_back(32'hFFFF_0000);
        applyStimulus(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 4'h0, 32'h40, 32'd0);
        aux_q.push_back(32'hCAFE_2222);
        applyIdle();
        applyIdle();

        // Reset right after an aux read grant drops the response.
        applyStimulus(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 4'h0, 32'h80, 32'd0);
        @(negedge clk);
        checkOutput("t6_aux_ready", {31'd0, aux_ready}, 32'd1);
        rst = 1'b1;
        applyIdle();
        @(negedge clk);
        checkOutput("t6_rsp_dropped", {31'd0, aux_rsp_valid}, 32'd0);
        checkIdleOutputs("t6");
        rst = 1'b0;
        applyIdle();

        // Reset clears a partly aged wait counter: 8 full CPU wins follow.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'h0, 32'h200, 32'd0, 1'b1, 4'h0, 32'h80, 32'd0);
            cpu_q.push_back(32'h1234_5678);
        end
        applyStimulus(1'b1, 4'hF, 32'h400, 32'd0, 1'b1, 4'h0, 32'h80, 32'd0);
        rst = 1'b1;
        applyStimulus(1'b1, 4'h0, 32'h200, 32'd0, 1'b1, 4'h0, 32'h80, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) applyStimulus(1'b1, 4'h0, 32'h200, 32'd0, 1'b1, 4'h0, 32'h80, 32'd0);
            if (i == 8) aux_q.push_back(32'hA5A5_A5A5);
            else        cpu_q.push_back(32'h1234_5678);
            @(negedge clk);
            checkOutput($sformatf("t6_wait_cleared_%0d", i), {31'd0, aux_ready},
                        (i == 8) ? 32'd1 : 32'd0);
        end

        applyIdle();
        applyIdle();
        applyIdle();
        @(negedge clk);
        checkOutput("cpu_q_drained", cpu_q.size(), 32'd0);
        checkOutput("aux_q_drained", aux_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
